wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl.sv | 69 ++++++
 tb/tb_wptr_full_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Produces the write address, Gray write pointer, full/almost-full flags, occupancy and a sticky overflow flag.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_THRESH = 508
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  wovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  woverflow
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbinnext;
  logic [ADDR_WIDTH:0] wgraynext;
  logic [ADDR_WIDTH:0] rbin_s;
  logic [ADDR_WIDTH:0] count_next;
  logic [ADDR_WIDTH:0] full_ptr;
  logic                wfull_next;
  logic                wafull_next;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign wbinnext   = wbin + {{ADDR_WIDTH{1'b0}}, winc & ~wfull};
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign count_next = wbinnext - rbin_s;

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
  assign full_ptr    = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
  assign wfull_next  = (wgraynext == full_ptr);
  assign wafull_next = (count_next >= AFULL_LVL);

  assign waddr = wbin[ADDR_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wafull    <= 1'b0;
      wcount    <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbinnext;
      wptr      <= wgraynext;
      wfull     <= wfull_next;
      wafull    <= wafull_next;
      wcount    <= count_next;
      woverflow <= (winc & wfull) | (woverflow & ~wovf_clr);
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl at ADDR_WIDTH=2, AFULL_THRESH=3.
// Table vectors plus hand-written reset, wrap and mid-burst reset sequences, checked through a queue.
module tb_wptr_full_ctrl;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [2:0] wq2_rptr;
  logic       wovf_clr;
  logic [1:0] waddr;
  logic [2:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [2:0] wcount;
  logic       woverflow;
  logic       clk_en;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] wptr;
    logic [1:0] waddr;
    logic       wfull;
    logic       wafull;
    logic [2:0] wcount;
    logic       wovf;
  } obs_t;

  typedef struct {
    logic       winc;
    logic [2:0] rptr;
    logic       clr;
    obs_t       exp;
    string      name;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[13];

  wptr_full_ctrl #(.ADDR_WIDTH(2), .AFULL_THRESH(3)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .winc      (winc),
    .wq2_rptr  (wq2_rptr),
    .wovf_clr  (wovf_clr),
    .waddr     (waddr),
    .wptr      (wptr),
    .wfull     (wfull),
    .wafull    (wafull),
    .wcount    (wcount),
    .woverflow (woverflow)
  );

  initial begin
    wclk = 1'b0;
    forever begin
      #5;
      if (clk_en) wclk = ~wclk;
    end
  end

  function automatic obs_t sample();
    return '{wptr, waddr, wfull, wafull, wcount, woverflow};
  endfunction

  function automatic logic [2:0] gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic apply(input logic inc, input logic [2:0] rp, input logic clr,
                       input obs_t exp, input string name);
    obs_t e;
    winc     = inc;
    wq2_rptr = rp;
    wovf_clr = clr;
    sb.push_back(exp);
    @(posedge wclk);
    #1;
    e = sb.pop_front();
    check(name, 32'(sample()), 32'(e));
  endtask

  task automatic pulse_reset();
    #1;
    wrst = 1'b1;
    winc = 1'b0;
    wovf_clr = 1'b0;
    @(posedge wclk);
    #1;
    wrst = 1'b0;
  endtask

  initial begin
    obs_t prev;
    vecs[0]  = '{1'b1, 3'b000, 1'b0, '{3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0}, "fill1"};
    vecs[1]  = '{1'b1, 3'b000, 1'b0, '{3'b011, 2'd2, 1'b0, 1'b0, 3'd2, 1'b0}, "fill2"};
    vecs[2]  = '{1'b1, 3'b000, 1'b0, '{3'b010, 2'd3, 1'b0, 1'b1, 3'd3, 1'b0}, "fill3_afull"};
    vecs[3]  = '{1'b1, 3'b000, 1'b0, '{3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0}, "fill4_full"};
    vecs[4]  = '{1'b1, 3'b000, 1'b0, '{3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b1}, "overflow_set"};
    vecs[5]  = '{1'b1, 3'b000, 1'b1, '{3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b1}, "ovf_set_wins"};
    vecs[6]  = '{1'b0, 3'b000, 1'b1, '{3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0}, "ovf_clear"};
    vecs[7]  = '{1'b0, 3'b001, 1'b0, '{3'b110, 2'd0, 1'b0, 1'b1, 3'd3, 1'b0}, "drain1"};
    vecs[8]  = '{1'b0, 3'b011, 1'b0, '{3'b110, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0}, "drain2"};
    vecs[9]  = '{1'b1, 3'b010, 1'b0, '{3'b111, 2'd1, 1'b0, 1'b0, 3'd2, 1'b0}, "rw_same_cycle"};
    vecs[10] = '{1'b1, 3'b010, 1'b0, '{3'b101, 2'd2, 1'b0, 1'b1, 3'd3, 1'b0}, "refill3"};
    vecs[11] = '{1'b1, 3'b010, 1'b0, '{3'b100, 2'd3, 1'b1, 1'b1, 3'd4, 1'b0}, "refill_full"};
    vecs[12] = '{1'b1, 3'b110, 1'b0, '{3'b100, 2'd3, 1'b0, 1'b1, 3'd3, 1'b1}, "blocked_write_read"};

    clk_en   = 1'b0;
    wrst     = 1'b0;
    winc     = 1'b0;
    wq2_rptr = 3'b000;
    wovf_clr = 1'b0;

    // Reset with the clock stopped must clear everything.
    #1 wrst = 1'b1;
    #1 check("reset_noclk", 32'(sample()), 32'(0));
    #2 wrst = 1'b0;
    clk_en = 1'b1;

    foreach (vecs[i]) apply(vecs[i].winc, vecs[i].rptr, vecs[i].clr, vecs[i].exp, vecs[i].name);

    // Wrap: read pointer trails by one entry, so the FIFO never fills.
    pulse_reset();
    prev = sample();
    for (int k = 1; k <= 9; k++) begin
      logic [2:0] kb;
      kb = 3'(k);
      apply(1'b1, gray(kb - 3'd1), 1'b0, '{gray(kb), kb[1:0], 1'b0, 1'b0, 3'd1, 1'b0}, "wrap");
      check("wrap_one_bit_step", 32'($countones(prev.wptr ^ wptr)), 32'(1));
      prev = sample();
    end

    // Asynchronous reset between edges with a burst in flight.
    pulse_reset();
    apply(1'b1, 3'b000, 1'b0, '{3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0}, "burst1");
    apply(1'b1, 3'b000, 1'b0, '{3'b011, 2'd2, 1'b0, 1'b0, 3'd2, 1'b0}, "burst2");
    #1 wrst = 1'b1;
    #1 check("reset_mid_burst", 32'(sample()), 32'(0));
    @(posedge wclk);
    #1 check("held_in_reset", 32'(sample()), 32'(0));
    wrst = 1'b0;
    #1 check("waddr_after_release", 32'(waddr), 32'(0));
    apply(1'b1, 3'b000, 1'b0, '{3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0}, "first_write_after_reset");

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
